ssd_frame_arbiter: RTL and testbench

SSD_FRAME_ARBITER -- requirements
Module: ssd_frame_arbiter

---
 rtl/ssd_frame_arbiter.sv | 142 ++++++++++++++
 tb/tb_ssd_frame_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_frame_arbiter.sv
// ssd_frame_arbiter: selects base frame or temporary message frames for the display.
// Optional blink of base digits is enabled by defining SSD_ARB_BLINK_EN.
module ssd_frame_arbiter #(
    parameter int MSG_CYCLES = 100000000,
    parameter int BLINK_HALF = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] base_frame,
    input  logic [3:0]  blink_mask,
    input  logic        msg_req,
    input  logic [19:0] msg_frame,
    input  logic        msg_flush,
    output logic        msg_ack,
    output logic [19:0] frame_out,
    output logic        frame_src
);

    localparam logic [4:0]  BLANK     = 5'h13;
    localparam logic [19:0] BLANK4    = {BLANK, BLANK, BLANK, BLANK};
    localparam logic [26:0] HOLD_LOAD = 27'(MSG_CYCLES - 1);

    typedef enum logic {
        BASE,
        MSG
    } state_t;

    state_t      state;
    logic [26:0] hold_cnt;
    logic [19:0] act_frame;
    logic        pend_valid;
    logic [19:0] pend_frame;
    logic [19:0] base_vis;

`ifdef SSD_ARB_BLINK_EN
    localparam logic [26:0] BLINK_LOAD = 27'(BLINK_HALF - 1);

    logic [26:0] blink_cnt;
    logic        blink_on;

    // Free-running half-period counter; phase flips at the end of each half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LOAD) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 27'd1;
        end
    end

    // Blank the masked base digits during the off phase.
    always_comb begin
        base_vis = base_frame;
        for (int k = 0; k < 4; k++) begin
            if (!blink_on && blink_mask[k]) begin
                base_vis[5*k +: 5] = BLANK;
            end
        end
    end
`else
    logic unused_blink;

    assign unused_blink = ^blink_mask;
    assign base_vis     = base_frame;
`endif

    // Message FSM with pending slot; outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BASE;
            hold_cnt   <= '0;
            act_frame  <= BLANK4;
            pend_valid <= 1'b0;
            pend_frame <= BLANK4;
            msg_ack    <= 1'b0;
            frame_out  <= BLANK4;
            frame_src  <= 1'b0;
        end else begin
            msg_ack <= 1'b0;
            if (msg_flush) begin
                state      <= BASE;
                hold_cnt   <= '0;
                pend_valid <= 1'b0;
                frame_out  <= base_vis;
                frame_src  <= 1'b0;
            end else begin
                unique case (state)
                    BASE: begin
                        if (msg_req) begin
                            act_frame <= msg_frame;
                            hold_cnt  <= HOLD_LOAD;
                            state     <= MSG;
                            msg_ack   <= 1'b1;
                            frame_out <= msg_frame;
                            frame_src <= 1'b1;
                        end else begin
                            frame_out <= base_vis;
                            frame_src <= 1'b0;
                        end
                    end
                    MSG: begin
                        if (hold_cnt != '0) begin
                            hold_cnt  <= hold_cnt - 27'd1;
                            frame_out <= act_frame;
                            frame_src <= 1'b1;
                            if (msg_req && !pend_valid) begin
                                pend_frame <= msg_frame;
                                pend_valid <= 1'b1;
                                msg_ack    <= 1'b1;
                            end
                        end else if (pend_valid) begin
                            act_frame  <= pend_frame;
                            pend_valid <= 1'b0;
                            hold_cnt   <= HOLD_LOAD;
                            frame_out  <= pend_frame;
                            frame_src  <= 1'b1;
                        end else if (msg_req) begin
                            act_frame <= msg_frame;
                            hold_cnt  <= HOLD_LOAD;
                            msg_ack   <= 1'b1;
                            frame_out <= msg_frame;
                            frame_src <= 1'b1;
                        end else begin
                            state     <= BASE;
                            frame_out <= base_vis;
                            frame_src <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= BASE;
                        frame_out <= base_vis;
                        frame_src <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ssd_frame_arbiter.sv
// tb_ssd_frame_arbiter: randomized and directed checks of ssd_frame_arbiter
// against a message-queue reference model (MSG_CYCLES=8, BLINK_HALF=4).
module tb_ssd_frame_arbiter;

    localparam int MC = 8;
    localparam int BH = 4;

    localparam logic [4:0] G_BL = 5'h13;
    localparam logic [4:0] G_1  = 5'h01;
    localparam logic [4:0] G_C  = 5'h0C;
    localparam logic [4:0] G_L  = 5'h15;
    localparam logic [4:0] G_S  = 5'h05;
    localparam logic [4:0] G_D  = 5'h0D;
    localparam logic [4:0] G_E  = 5'h0E;
    localparam logic [4:0] G_T  = 5'h12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] base_frame = '0;
    logic [3:0]  blink_mask = '0;
    logic        msg_req = 1'b0;
    logic [19:0] msg_frame = '0;
    logic        msg_flush = 1'b0;
    logic        msg_ack;
    logic [19:0] frame_out;
    logic        frame_src;

    int errors = 0;
    int checks = 0;

    // reference model: active message with cycles left, one pending slot
    bit          m_active = 0;
    logic [19:0] m_frame = '0;
    int          m_left = 0;
    bit          m_pend = 0;
    logic [19:0] m_pframe = '0;
    int          m_edges = 0;
    logic        e_ack = 1'b0;
    logic        e_src = 1'b0;
    logic [19:0] e_frame = 20'h9CE73;

    ssd_frame_arbiter #(
        .MSG_CYCLES(MC),
        .BLINK_HALF(BH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .base_frame(base_frame),
        .blink_mask(blink_mask),
        .msg_req   (msg_req),
        .msg_frame (msg_frame),
        .msg_flush (msg_flush),
        .msg_ack   (msg_ack),
        .frame_out (frame_out),
        .frame_src (frame_src)
    );

    always #5 clk = ~clk;

    // n = clock edges since reset release; phase is off in odd half-periods
    function automatic logic [19:0] shown_base(input logic [19:0] b,
                                               input logic [3:0] m,
                                               input int n);
        logic [19:0] r;
        r = b;
`ifdef SSD_ARB_BLINK_EN
        for (int k = 0; k < 4; k++) begin
            if ((((n - 1) / BH) % 2 == 1) && m[k]) r[5*k +: 5] = G_BL;
        end
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_pend   = 0;
        m_left   = 0;
        m_edges  = 0;
        e_ack    = 1'b0;
        e_src    = 1'b0;
        e_frame  = 20'h9CE73;
    endtask

    // drive one cycle of inputs, advance model at the edge, return at negedge
    task automatic step(input logic req, input logic fl, input logic [19:0] mf);
        msg_req   = req;
        msg_flush = fl;
        msg_frame = mf;
        @(posedge clk);
        m_edges++;
        e_ack = 1'b0;
        if (fl) begin
            m_active = 0;
            m_pend   = 0;
        end else if (!m_active) begin
            if (req) begin
                m_active = 1;
                m_frame  = mf;
                m_left   = MC;
                e_ack    = 1'b1;
            end
        end else begin
            m_left--;
            if (m_left > 0) begin
                if (req && !m_pend) begin
                    m_pend   = 1;
                    m_pframe = mf;
                    e_ack    = 1'b1;
                end
            end else if (m_pend) begin
                m_frame = m_pframe;
                m_pend  = 0;
                m_left  = MC;
            end else if (req) begin
                m_frame = mf;
                m_left  = MC;
                e_ack   = 1'b1;
            end else begin
                m_active = 0;
            end
        end
        e_src   = m_active;
        e_frame = m_active ? m_frame : shown_base(base_frame, blink_mask, m_edges);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        base_frame = {G_C, G_L, G_S, G_D};
        blink_mask = 4'b0000;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (frame_out !== 20'h9CE73) begin
            errors++;
            $display("FAIL reset_frame: got %h want %h", frame_out, 20'h9CE73);
        end
        checks++;
        if ({msg_ack, frame_src} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: ack/src got %b/%b want 0/0", msg_ack, frame_src);
        end
        rst = 1'b0;
        step(1'b0, 1'b0, '0);
        checks++;
        if (frame_out !== {G_C, G_L, G_S, G_D} || frame_src !== 1'b0) begin
            errors++;
            $display("FAIL release_base: frame/src got %h/%b want %h/0",
                     frame_out, frame_src, {G_C, G_L, G_S, G_D});
        end
    endtask

    task automatic test_single_msg();
        logic [19:0] fm;
        int shown;
        int acks;
        fm = {G_E, G_T, G_T, G_T};
        shown = 0;
        acks = 0;
        for (int i = 0; i < 13; i++) begin
            step(i == 0, 1'b0, (i == 0) ? fm : 20'h0);
            if (frame_src === 1'b1 && frame_out === fm) shown++;
            if (msg_ack === 1'b1) acks++;
            checks++;
            if ({msg_ack, frame_src, frame_out} !== {e_ack, e_src, e_frame}) begin
                errors++;
                $display("FAIL single c%0d: ack/src/frame %b/%b/%h want %b/%b/%h",
                         i, msg_ack, frame_src, frame_out, e_ack, e_src, e_frame);
            end
        end
        checks++;
        if (shown !== MC || acks !== 1) begin
            errors++;
            $display("FAIL single_len: shown %0d acks %0d want %0d 1", shown, acks, MC);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] fa, fb, fc;
        int waited;
        fa = {G_E, G_1, G_1, G_1};
        fb = {G_E, G_S, G_S, G_S};
        fc = {G_E, G_C, G_C, G_C};
        waited = -1;
        for (int i = 0; i < 5; i++) begin
            step(i == 0 || i == 4, 1'b0, (i == 4) ? fb : fa);
            checks++;
            if ({msg_ack, frame_src, frame_out} !== {e_ack, e_src, e_frame}) begin
                errors++;
                $display("FAIL b2b_ab c%0d: ack/src/frame %b/%b/%h want %b/%b/%h",
                         i, msg_ack, frame_src, frame_out, e_ack, e_src, e_frame);
            end
        end
        checks++;
        if (msg_ack !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ack_b: ack got %b want 1", msg_ack);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, fc);
            checks++;
            if ({msg_ack, frame_src, frame_out} !== {e_ack, e_src, e_frame}) begin
                errors++;
                $display("FAIL b2b_c c%0d: ack/src/frame %b/%b/%h want %b/%b/%h",
                         i, msg_ack, frame_src, frame_out, e_ack, e_src, e_frame);
            end
            if (msg_ack === 1'b1) begin
                waited = i;
                break;
            end
        end
        checks++;
        if (waited !== 4) begin
            errors++;
            $display("FAIL b2b_c_wait: acked after %0d want 4", waited);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, '0);
            checks++;
            if ({msg_ack, frame_src, frame_out} !== {e_ack, e_src, e_frame}) begin
                errors++;
                $display("FAIL b2b_tail c%0d: ack/src/frame %b/%b/%h want %b/%b/%h",
                         i, msg_ack, frame_src, frame_out, e_ack, e_src, e_frame);
            end
        end
    endtask

    task automatic test_flush();
        logic [19:0] fa, fb;
        fa = {G_E, G_D, G_D, G_D};
        fb = {G_E, G_L, G_L, G_L};
        for (int i = 0; i < 16; i++) begin
            step(i == 0 || i == 2 || i == 4, i == 4, (i == 2) ? fb : fa);
            checks++;
            if ({msg_ack, frame_src, frame_out} !== {e_ack, e_src, e_frame}) begin
                errors++;
                $display("FAIL flush c%0d: ack/src/frame %b/%b/%h want %b/%b/%h",
                         i, msg_ack, frame_src, frame_out, e_ack, e_src, e_frame);
            end
            if (i == 4) begin
                checks++;
                if ({msg_ack, frame_src} !== 2'b00 || frame_out !== base_frame) begin
                    errors++;
                    $display("FAIL flush_now: ack/src/frame %b/%b/%h want 0/0/%h",
                             msg_ack, frame_src, frame_out, base_frame);
                end
            end
        end
    endtask

    task automatic test_blink();
        logic [19:0] fm;
        fm = {G_E, G_T, G_1, G_T};
        base_frame = {G_1, G_T, G_T, G_T};
        blink_mask = 4'b1000;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, '0);
            checks++;
            if ({msg_ack, frame_src, frame_out} !== {e_ack, e_src, e_frame}) begin
                errors++;
                $display("FAIL blink c%0d: ack/src/frame %b/%b/%h want %b/%b/%h",
                         i, msg_ack, frame_src, frame_out, e_ack, e_src, e_frame);
            end
        end
`ifdef SSD_ARB_BLINK_EN
        for (int i = 0; i < 2 * BH + 1; i++) begin
            if (e_frame[19:15] == G_BL && (m_edges % BH) != 0) break;
            step(1'b0, 1'b0, '0);
        end
`endif
        step(1'b1, 1'b0, fm);
        checks++;
        if (frame_out !== fm || frame_src !== 1'b1 || msg_ack !== 1'b1) begin
            errors++;
            $display("FAIL blink_msg: ack/src/frame %b/%b/%h want 1/1/%h",
                     msg_ack, frame_src, frame_out, fm);
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, '0);
            checks++;
            if ({msg_ack, frame_src, frame_out} !== {e_ack, e_src, e_frame}) begin
                errors++;
                $display("FAIL blink_tail c%0d: ack/src/frame %b/%b/%h want %b/%b/%h",
                         i, msg_ack, frame_src, frame_out, e_ack, e_src, e_frame);
            end
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        blink_mask = 4'b0000;
        step(1'b1, 1'b0, {G_E, G_1, G_S, G_D});
        step(1'b1, 1'b0, {G_E, G_D, G_S, G_1});
        step(1'b0, 1'b0, '0);
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({msg_ack, frame_src, frame_out} !== {2'b00, 20'h9CE73}) begin
            errors++;
            $display("FAIL mid_reset: ack/src/frame %b/%b/%h want 0/0/9ce73",
                     msg_ack, frame_src, frame_out);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, '0);
            if (msg_ack !== 1'b0 || frame_src !== 1'b0) bad++;
            checks++;
            if ({msg_ack, frame_src, frame_out} !== {e_ack, e_src, e_frame}) begin
                errors++;
                $display("FAIL mid_after c%0d: ack/src/frame %b/%b/%h want %b/%b/%h",
                         i, msg_ack, frame_src, frame_out, e_ack, e_src, e_frame);
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL mid_stale: %0d cycles with ack/src set, want 0", bad);
        end
    endtask

    task automatic test_random();
        logic rq, fl;
        logic [19:0] mf;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) base_frame = 20'($urandom);
            if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
            rq = ($urandom_range(0, 9) < 4);
            fl = ($urandom_range(0, 29) == 0);
            mf = 20'($urandom);
            step(rq, fl, mf);
            checks++;
            if ({msg_ack, frame_src, frame_out} !== {e_ack, e_src, e_frame}) begin
                errors++;
                $display("FAIL random c%0d: ack/src/frame %b/%b/%h want %b/%b/%h",
                         i, msg_ack, frame_src, frame_out, e_ack, e_src, e_frame);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_msg();
        test_back_to_back();
        test_flush();
        test_blink();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
